// File: rtl/hazard_scoreboard.sv
// Hazard detection beside ID: tracks in-flight destinations in a shift scoreboard
// and stalls on RAW matches (or load-use only when forwarding) and multi-cycle ops.
module hazard_scoreboard #(
  parameter int unsigned ADDRESS_LEN_REG_FILE = 4,
  parameter int unsigned PIPE_DEPTH           = 2,
  parameter int unsigned FORWARD_EN           = 0,
  parameter int unsigned MC_LAT               = 3,
  parameter int unsigned STAT_W               = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            issue_valid,
  input  logic [ADDRESS_LEN_REG_FILE-1:0] src1,
  input  logic [ADDRESS_LEN_REG_FILE-1:0] src2,
  input  logic                            two_src,
  input  logic                            issue_wb_en,
  input  logic [ADDRESS_LEN_REG_FILE-1:0] issue_dest,
  input  logic                            issue_is_load,
  input  logic                            issue_multicycle,
  output logic                            hazard_detected,
  output logic                            mc_busy,
  output logic [STAT_W-1:0]               stall_cycles
);

  localparam int unsigned CNT_W = $clog2(MC_LAT);

  typedef enum logic {
    MC_IDLE,
    MC_BUSY
  } mc_state_e;

  logic [PIPE_DEPTH-1:0]           valid_q, valid_d;
  logic [ADDRESS_LEN_REG_FILE-1:0] dest_q [PIPE_DEPTH];
  logic [ADDRESS_LEN_REG_FILE-1:0] dest_d [PIPE_DEPTH];
  logic                            load0_q, load0_d;
  mc_state_e                       state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [STAT_W-1:0]               stall_q, stall_d;

  logic [PIPE_DEPTH-1:0] match;
  logic                  fwd_mode;
  logic                  data_hazard;
  logic                  accept;

  assign fwd_mode = (FORWARD_EN != 0);
  assign mc_busy  = (state_q == MC_BUSY);

  always_comb begin
    match = '0;
    for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
      match[k] = valid_q[k] & ((src1 == dest_q[k]) | (two_src & (src2 == dest_q[k])));
    end
  end

  // Only entry 0's load flag can ever cause a stall, so older entries do not keep one.
  assign data_hazard     = fwd_mode ? (match[0] & load0_q) : (|match);
  assign hazard_detected = !flush & (mc_busy | (issue_valid & data_hazard));
  assign accept          = issue_valid & !hazard_detected & !flush;
  assign stall_cycles    = stall_q;

  always_comb begin
    valid_d = valid_q;
    dest_d  = dest_q;
    load0_d = load0_q;
    if (flush) begin
      valid_d = '0;
    end else if (!mc_busy) begin
      for (int unsigned k = 1; k < PIPE_DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        dest_d[k]  = dest_q[k-1];
      end
      valid_d[0] = accept & issue_wb_en;
      dest_d[0]  = issue_dest;
      load0_d    = accept & issue_wb_en & issue_is_load;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = MC_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        MC_IDLE: begin
          if (accept & issue_multicycle) begin
            state_d = MC_BUSY;
            cnt_d   = CNT_W'(MC_LAT - 2);
          end
        end
        MC_BUSY: begin
          if (cnt_q == '0) begin
            state_d = MC_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = MC_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (hazard_detected && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      load0_q <= 1'b0;
      state_q <= MC_IDLE;
      cnt_q   <= '0;
      stall_q <= '0;
      for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
        dest_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      load0_q <= load0_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
        dest_q[k] <= dest_d[k];
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: two instances (no forwarding / forwarding) share stimulus;
// expectations are queued by the stimulus and checked by a negedge monitor.
module tb_hazard_scoreboard;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       iv;
  logic [3:0] s1, s2, dst;
  logic       two, wb, ld, mc;
  logic       hz0, busy0, hz1, busy1;
  logic [3:0] st0;
  logic [15:0] st1;

  typedef struct {
    string name;
    int    dut;
    logic  hz;
    logic  busy;
    int    stall;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  hazard_scoreboard #(
    .ADDRESS_LEN_REG_FILE(4), .PIPE_DEPTH(2), .FORWARD_EN(0), .MC_LAT(3), .STAT_W(4)
  ) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .issue_valid(iv), .src1(s1), .src2(s2),
    .two_src(two), .issue_wb_en(wb), .issue_dest(dst), .issue_is_load(ld),
    .issue_multicycle(mc), .hazard_detected(hz0), .mc_busy(busy0), .stall_cycles(st0)
  );

  hazard_scoreboard #(
    .ADDRESS_LEN_REG_FILE(4), .PIPE_DEPTH(2), .FORWARD_EN(1), .MC_LAT(3), .STAT_W(16)
  ) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .issue_valid(iv), .src1(s1), .src2(s2),
    .two_src(two), .issue_wb_en(wb), .issue_dest(dst), .issue_is_load(ld),
    .issue_multicycle(mc), .hazard_detected(hz1), .mc_busy(busy1), .stall_cycles(st1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_in(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic t, input logic w, input logic [3:0] d,
                        input logic l, input logic m, input logic f);
    iv = v; s1 = a; s2 = b; two = t; wb = w; dst = d; ld = l; mc = m; flush = f;
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic t, input logic w, input logic [3:0] d,
                       input logic l, input logic m, input logic f);
    @(posedge clk);
    #1;
    set_in(v, a, b, t, w, d, l, m, f);
  endtask

  task automatic push_exp(input string nm, input int d, input logic h,
                          input logic b, input int s);
    exp_t e;
    e.name = nm; e.dut = d; e.hz = h; e.busy = b; e.stall = s;
    q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic ah, ab;
      int   as;
      e  = q.pop_front();
      ah = (e.dut == 0) ? hz0 : hz1;
      ab = (e.dut == 0) ? busy0 : busy1;
      as = (e.dut == 0) ? int'(st0) : int'(st1);
      n_tests++;
      if (ah !== e.hz) begin
        n_fail++;
        $display("FAIL %s dut%0d hazard got %b want %b", e.name, e.dut, ah, e.hz);
      end
      n_tests++;
      if (ab !== e.busy) begin
        n_fail++;
        $display("FAIL %s dut%0d mc_busy got %b want %b", e.name, e.dut, ab, e.busy);
      end
      if (e.stall >= 0) begin
        n_tests++;
        if (as != e.stall) begin
          n_fail++;
          $display("FAIL %s dut%0d stall_cycles got %0d want %0d", e.name, e.dut, as, e.stall);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_in(1, 0, 0, 1, 1, 0, 1, 1, 0);
    #1;
    push_exp("reset_state", 0, 0, 0, 0);
    push_exp("reset_state", 1, 0, 0, 0);

    // RAW on a non-forwarded pipe: two stall cycles
    do_reset();
    drive(1, 1, 2, 1, 1, 3, 0, 0, 0); push_exp("a_writer", 0, 0, 0, 0);
    drive(1, 3, 0, 0, 1, 4, 0, 0, 0); push_exp("a_raw_t1", 0, 1, 0, 0);
                                      push_exp("fwd_alu_dep", 1, 0, 0, 0);
    drive(1, 3, 0, 0, 1, 4, 0, 0, 0); push_exp("a_raw_t2", 0, 1, 0, 1);
    drive(1, 3, 0, 0, 1, 4, 0, 0, 0); push_exp("a_raw_t3", 0, 0, 0, 2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); push_exp("a_idle", 0, 0, 0, 2);

    // src2 only counts when two_src
    do_reset();
    drive(1, 0, 0, 0, 1, 7, 0, 0, 0); push_exp("b_writer", 0, 0, 0, 0);
    drive(1, 1, 7, 0, 0, 0, 0, 0, 0); push_exp("b_one_src", 0, 0, 0, 0);
    drive(1, 1, 7, 1, 0, 0, 0, 0, 0); push_exp("b_two_src", 0, 1, 0, 0);

    // load-use with forwarding: exactly one stall
    do_reset();
    drive(1, 0, 0, 0, 1, 5, 1, 0, 0); push_exp("c_load", 1, 0, 0, 0);
    drive(1, 5, 0, 0, 0, 0, 0, 0, 0); push_exp("c_lu_t1", 1, 1, 0, 0);
                                      push_exp("c_lu_nofwd", 0, 1, 0, 0);
    drive(1, 5, 0, 0, 0, 0, 0, 0, 0); push_exp("c_lu_t2", 1, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); push_exp("c_lu_end", 1, 0, 0, 1);

    // multi-cycle op: two busy cycles, scoreboard frozen meanwhile
    do_reset();
    drive(1, 1, 0, 0, 1, 6, 0, 1, 0); push_exp("d_mc_accept", 0, 0, 0, 0);
    drive(1, 2, 0, 0, 1, 8, 0, 0, 0); push_exp("d_busy1", 0, 1, 1, 0);
    drive(1, 2, 0, 0, 1, 8, 0, 0, 0); push_exp("d_busy2", 0, 1, 1, 1);
    drive(1, 6, 0, 0, 0, 0, 0, 0, 0); push_exp("d_frozen_e0", 0, 1, 0, 2);
                                      push_exp("d_fwd_idle", 1, 0, 0, 2);
    drive(1, 6, 0, 0, 0, 0, 0, 0, 0); push_exp("d_e1", 0, 1, 0, 3);
    drive(1, 6, 0, 0, 0, 0, 0, 0, 0); push_exp("d_retired", 0, 0, 0, 4);

    // flush with a load in entry 0 and the FSM busy
    do_reset();
    drive(1, 0, 0, 0, 1, 9, 1, 1, 0); push_exp("e_accept", 0, 0, 0, 0);
    drive(1, 9, 0, 0, 0, 0, 0, 0, 1); push_exp("e_flush", 0, 0, 1, 0);
                                      push_exp("e_flush", 1, 0, 1, 0);
    drive(1, 9, 0, 0, 0, 0, 0, 0, 0); push_exp("e_after", 0, 0, 0, 0);
                                      push_exp("e_after", 1, 0, 0, 0);

    // back-to-back multi-cycle ops: busy whenever i%3 != 0; saturate at 15
    do_reset();
    for (int i = 0; i < 32; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
      if (i == 22) push_exp("f_pre_sat", 0, 1, 1, 14);
      if (i == 23) push_exp("f_sat", 0, 1, 1, 15);
      if (i == 24) push_exp("f_hold_sat", 0, 0, 0, 15);
      if (i == 30) push_exp("f_sat_late", 0, 0, 0, 15);
      if (i == 31) push_exp("f_busy_late", 0, 1, 1, 15);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    push_exp("f_async_rst", 0, 0, 0, 0);
    push_exp("f_async_rst", 1, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
